// File: rtl/pcw_timer_pkg.sv
// Shared types and constants for the PCW 300 Hz frame timer.
package pcw_timer_pkg;

  // FDC interrupt routing selected through the system-control port.
  typedef enum logic [1:0] {
    FDC_NONE = 2'b00,
    FDC_INT  = 2'b01,
    FDC_NMI  = 2'b10,
    FDC_RSVD = 2'b11
  } fdc_route_t;

  localparam int CE_HZ_DEF   = 1_000_000;
  localparam int TICK_HZ_DEF = 300;
  localparam int CNT_W_DEF   = 4;

  // Number of bits needed to hold the values 0 .. div-1 (at least one).
  function automatic int div_width(input int div);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < div) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  localparam int DIV_DEF   = CE_HZ_DEF / TICK_HZ_DEF;
  localparam int DIV_W_DEF = div_width(DIV_DEF);

  // The reserved route code behaves exactly like "no routing".
  function automatic fdc_route_t route_norm(input logic [1:0] code);
    fdc_route_t r;
    case (code)
      2'b01:   r = FDC_INT;
      2'b10:   r = FDC_NMI;
      default: r = FDC_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pcw_tick_divider.sv
// Clock-enable gated modulo-DIV counter producing a registered one-clk tick.
module pcw_tick_divider
  import pcw_timer_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // Advance on each enable, wrap at DIV-1 and flag the wrap for exactly one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (ce) begin
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/pcw_tick_timer.sv
// PCW frame timer: 300 Hz tick, F4 tick counter, Z80 INT/NMI generation and FDC routing.
module pcw_tick_timer
  import pcw_timer_pkg::*;
#(
  parameter int CE_HZ   = CE_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_1mhz,
  input  logic       rd_f4,
  output logic [7:0] f4_dout,
  input  logic       timer_en,
  input  logic       fdc_route_wr,
  input  logic [1:0] fdc_route_in,
  input  logic       fdc_int,
  input  logic       nmi_ack,
  output logic       int_n,
  output logic       nmi_n,
  output logic       tick
);

  localparam int DIV   = CE_HZ / TICK_HZ;
  localparam int DIV_W = div_width(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_tick;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       r_f4_dout;
  fdc_route_t       r_route;
  fdc_route_t       w_route_wr;
  logic             r_fdc_int_d;
  logic             r_int_n;
  logic             r_nmi_n;
  logic             w_int_req;
  logic             w_fdc_rise;
  logic             w_leave_nmi;
  logic             w_nmi_pend;
  logic             w_nmi_pend_nxt;

  pcw_tick_divider #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_1mhz),
    .tick  (w_tick)
  );

  // Next tick count, pending-NMI state and INT request from current registered state.
  always_comb begin
    w_count_nxt    = r_count;
    w_nmi_pend_nxt = 1'b0;
    w_route_wr     = route_norm(fdc_route_in);
    w_nmi_pend     = ~r_nmi_n;
    w_fdc_rise     = fdc_int & ~r_fdc_int_d;
    w_leave_nmi    = fdc_route_wr & (w_route_wr != FDC_NMI);
    w_int_req      = (timer_en & (r_count != '0)) |
                     ((r_route == FDC_INT) & fdc_int);

    // A read clears the count, but a tick arriving in the same clk is kept.
    if (rd_f4) begin
      w_count_nxt = w_tick ? CNT_W'(1) : '0;
    end else if (w_tick && (r_count != CNT_MAX)) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end

    // A fresh FDC edge beats an acknowledge; leaving NMI routing drops the request.
    if ((r_route != FDC_NMI) || w_leave_nmi) begin
      w_nmi_pend_nxt = 1'b0;
    end else if (w_fdc_rise) begin
      w_nmi_pend_nxt = 1'b1;
    end else if (nmi_ack) begin
      w_nmi_pend_nxt = 1'b0;
    end else begin
      w_nmi_pend_nxt = w_nmi_pend;
    end
  end

  // State and output registers; the read data captures the count before this clk's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_f4_dout   <= 8'h00;
      r_route     <= FDC_NONE;
      r_fdc_int_d <= 1'b0;
      r_int_n     <= 1'b1;
      r_nmi_n     <= 1'b1;
    end else begin
      r_count     <= w_count_nxt;
      r_fdc_int_d <= fdc_int;
      r_int_n     <= ~w_int_req;
      r_nmi_n     <= ~w_nmi_pend_nxt;
      if (rd_f4) begin
        r_f4_dout <= 8'(r_count);
      end else begin
        r_f4_dout <= r_f4_dout;
      end
      if (fdc_route_wr) begin
        r_route <= w_route_wr;
      end else begin
        r_route <= r_route;
      end
    end
  end

  assign f4_dout = r_f4_dout;
  assign int_n   = r_int_n;
  assign nmi_n   = r_nmi_n;
  assign tick    = w_tick;

endmodule

// File: tb/tb_pcw_tick_timer.sv
// Self-checking bench for pcw_tick_timer: directed sequences plus a routing vector table.
module tb_pcw_tick_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_1mhz;
  logic       rd_f4;
  logic [7:0] f4_dout;
  logic       timer_en;
  logic       fdc_route_wr;
  logic [1:0] fdc_route_in;
  logic       fdc_int;
  logic       nmi_ack;
  logic       int_n;
  logic       nmi_n;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       wr;
    logic [1:0] rin;
    logic       fi;
    logic       ack;
    logic       exp_int_n;
    logic       exp_nmi_n;
  } vec_t;

  vec_t vecs [18];

  pcw_tick_timer dut (
    .clk          (clk),
    .reset        (reset),
    .ce_1mhz      (ce_1mhz),
    .rd_f4        (rd_f4),
    .f4_dout      (f4_dout),
    .timer_en     (timer_en),
    .fdc_route_wr (fdc_route_wr),
    .fdc_route_in (fdc_route_in),
    .fdc_int      (fdc_int),
    .nmi_ack      (nmi_ack),
    .int_n        (int_n),
    .nmi_n        (nmi_n),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs ce every clk until tick is seen; returns number of ce pulses applied.
  task automatic ce_until_tick(input int max_ce, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    ce_1mhz = 1'b1;
    while (!seen && n < max_ce) begin
      step();
      n++;
      if (tick) seen = 1'b1;
    end
    ce_1mhz = 1'b0;
  endtask

  task automatic run_ticks(input int k);
    int n;
    for (int i = 0; i < k; i++) begin
      ce_until_tick(4000, n);
      chk("tick_period", n, 3333);
    end
  endtask

  task automatic do_read();
    rd_f4 = 1'b1;
    step();
    rd_f4 = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; ce_1mhz = 1'b0; rd_f4 = 1'b0; timer_en = 1'b0;
    fdc_route_wr = 1'b0; fdc_route_in = 2'b00; fdc_int = 1'b0; nmi_ack = 1'b0;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) step();
    chk("rst_dout", 32'(f4_dout), 32'h00);
    chk("rst_int_n", 32'(int_n), 32'h1);
    chk("rst_nmi_n", 32'(nmi_n), 32'h1);
    chk("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    step();

    // First tick after exactly DIV ce pulses, tick lasts one clk
    ce_until_tick(4000, n);
    chk("first_tick", n, 3333);
    step();
    chk("tick_one_clk", 32'(tick), 32'h0);
    do_read();
    chk("rd_count1", 32'(f4_dout), 32'h01);
    ce_until_tick(4000, n);
    chk("second_tick", n, 3333);
    step();

    // Park divider at 2000 with count 1, INT active and an NMI pending, then reset mid-cycle
    ce_1mhz = 1'b1;
    repeat (2000) step();
    ce_1mhz = 1'b0;
    timer_en = 1'b1;
    step();
    chk("int_before_rst", 32'(int_n), 32'h0);
    fdc_route_wr = 1'b1; fdc_route_in = 2'b10;
    step();
    fdc_route_wr = 1'b0; fdc_int = 1'b1;
    step();
    chk("nmi_before_rst", 32'(nmi_n), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dout", 32'(f4_dout), 32'h00);
    chk("async_rst_int_n", 32'(int_n), 32'h1);
    chk("async_rst_nmi_n", 32'(nmi_n), 32'h1);
    chk("async_rst_tick", 32'(tick), 32'h0);
    fdc_int = 1'b0; timer_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    ce_until_tick(4000, n);
    chk("tick_after_rst", n, 3333);
    step();

    // Count to 3, then read in the same clk as the 4th tick
    run_ticks(2);
    step();
    ce_until_tick(4000, n);
    chk("tick_period", n, 3333);
    rd_f4 = 1'b1;
    step();
    rd_f4 = 1'b0;
    chk("rd_with_tick", 32'(f4_dout), 32'h03);
    do_read();
    chk("rd_after_coincident", 32'(f4_dout), 32'h01);
    do_read();
    chk("rd_cleared", 32'(f4_dout), 32'h00);

    // FDC routing and NMI edge/ack behaviour
    for (int i = 0; i < 18; i++) begin
      fdc_route_wr = vecs[i].wr;
      fdc_route_in = vecs[i].rin;
      fdc_int      = vecs[i].fi;
      nmi_ack      = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_int_n", i), 32'(int_n), 32'(vecs[i].exp_int_n));
      chk($sformatf("vec%0d_nmi_n", i), 32'(nmi_n), 32'(vecs[i].exp_nmi_n));
    end
    fdc_route_wr = 1'b0; fdc_route_in = 2'b00; fdc_int = 1'b0; nmi_ack = 1'b0;
    step();

    // timer_en gating at count 5, then saturation and clearing read
    run_ticks(5);
    step();
    chk("int_masked", 32'(int_n), 32'h1);
    timer_en = 1'b1;
    step();
    chk("int_enabled", 32'(int_n), 32'h0);
    run_ticks(12);
    step();
    chk("int_before_read", 32'(int_n), 32'h0);
    do_read();
    chk("rd_saturated", 32'(f4_dout), 32'h0F);
    chk("int_at_read", 32'(int_n), 32'h0);
    step();
    chk("int_after_read", 32'(int_n), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
